fpadd_vector_checker: RTL

//  On-board, synthesisable successor to the FP-adder simulation bench.
//  - Streams NUM {A,B,expected} vectors from a synchronous vector ROM into a pipelined FP adder, one vector per cycle.
//  - Compares each adder result against its delayed expected value and counts mismatches.
//  - Reports pass/fail, error count and first failing index for LED/ILA readout on the Zedboard.

---
 rtl/fpadd_vector_checker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fpadd_vector_checker.sv
// rtl/fpadd_vector_checker.sv - streams ROM vectors into a pipelined FP adder and scores the results.
// Optional: FPCHK_NAN_EQUIV_EN makes any result NaN match any expected NaN.
module fpadd_vector_checker #(
    parameter int WIDTH   = 32,
    parameter int NUM     = 10,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8,
    localparam int AW     = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [AW-1:0]        vec_addr,
    input  logic [3*WIDTH-1:0]   vec_data,
    output logic [WIDTH-1:0]     dut_A,
    output logic [WIDTH-1:0]     dut_B,
    input  logic [WIDTH-1:0]     dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     err_count,
    output logic [AW-1:0]        first_err_idx
);

    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             start_acc;
    logic             issue_en;
    logic [AW-1:0]    issue_idx;
    logic [DW-1:0]    drain_cnt;
    logic             tail_match;

    logic             dl_valid [LATENCY];
    logic [WIDTH-1:0] dl_exp   [LATENCY];
    logic [AW-1:0]    dl_idx   [LATENCY];

`ifdef FPCHK_NAN_EQUIV_EN
    localparam int EXP_W = (WIDTH == 64) ? 11 : (WIDTH == 16) ? 5 : 8;
    localparam int MAN_W = WIDTH - 1 - EXP_W;

    function automatic logic is_nan(input logic [WIDTH-1:0] x);
        return (&x[WIDTH-2 -: EXP_W]) && (|x[MAN_W-1:0]);
    endfunction
`endif

    always_comb begin
        tail_match = (dut_out == dl_exp[LATENCY-1]);
`ifdef FPCHK_NAN_EQUIV_EN
        if (is_nan(dut_out) && is_nan(dl_exp[LATENCY-1]))
            tail_match = 1'b1;
`endif
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        issue_en  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                issue_en = 1'b1;
                if (issue_idx == LAST_IDX)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // The address runs one ahead of issue_idx to hide the ROM's read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec_addr      <= '0;
            issue_idx     <= '0;
            drain_cnt     <= '0;
            dut_A         <= '0;
            dut_B         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mismatch      <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            mismatch <= 1'b0;
            if (start_acc) begin
                vec_addr      <= '0;
                issue_idx     <= '0;
                drain_cnt     <= '0;
                err_count     <= '0;
                first_err_idx <= '0;
                done          <= 1'b0;
                busy          <= 1'b1;
            end
            if ((state_q == S_FETCH || state_q == S_ISSUE) && vec_addr != LAST_IDX)
                vec_addr <= vec_addr + 1'b1;
            if (issue_en) begin
                dut_A <= vec_data[3*WIDTH-1:2*WIDTH];
                dut_B <= vec_data[2*WIDTH-1:WIDTH];
                if (issue_idx != LAST_IDX)
                    issue_idx <= issue_idx + 1'b1;
            end
            if (state_q == S_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
            if (dl_valid[LATENCY-1] && !tail_match) begin
                mismatch <= 1'b1;
                if (err_count != {CNT_W{1'b1}})
                    err_count <= err_count + 1'b1;
                if (err_count == '0)
                    first_err_idx <= dl_idx[LATENCY-1];
            end
        end
    end

    // Expected value and index travel alongside the adder pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl_valid[i] <= 1'b0;
                dl_exp[i]   <= '0;
                dl_idx[i]   <= '0;
            end
        end else begin
            dl_valid[0] <= issue_en;
            dl_exp[0]   <= vec_data[WIDTH-1:0];
            dl_idx[0]   <= issue_idx;
            for (int i = 1; i < LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_exp[i]   <= dl_exp[i-1];
                dl_idx[i]   <= dl_idx[i-1];
            end
        end
    end

    assign pass = done && (err_count == '0);

endmodule
